// File: rtl/peripheral_dbg_soc_dii_packetizer_pkg.sv
// Shared flit type for the debug interconnect (DII) link.
package peripheral_dbg_soc_dii_packetizer_pkg;

  // One flit on the DII link toward the router local input.
  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic        last;
  } dii_flit;

endpackage

// File: rtl/peripheral_dbg_soc_dii_packetizer.sv
// Turns a single event request into a DII packet: DEST, SRC, FLAGS, then payload words.
module peripheral_dbg_soc_dii_packetizer
  import peripheral_dbg_soc_dii_packetizer_pkg::*;
#(
  parameter int unsigned MAX_DATA_NUM_WORDS = 8,
  parameter logic [1:0]  PKT_TYPE           = 2'b10
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [15:0]                               id,
  input  logic [15:0]                               dest,
  input  logic [3:0]                                type_sub,
  input  logic                                      event_available,
  output logic                                      event_consumed,
  input  logic [$clog2(MAX_DATA_NUM_WORDS+1)-1:0]   data_num_words,
  input  logic [MAX_DATA_NUM_WORDS*16-1:0]          data,
  output dii_flit                                   debug_out,
  input  logic                                      debug_out_ready
);

  localparam int unsigned LEN_W  = $clog2(MAX_DATA_NUM_WORDS + 1);
  localparam int unsigned DATA_W = MAX_DATA_NUM_WORDS * 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEST    = 3'd1;
  localparam logic [2:0] ST_SRC     = 3'd2;
  localparam logic [2:0] ST_FLAGS   = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       dest_q, dest_d;
  logic [15:0]       id_q, id_d;
  logic [3:0]        type_sub_q, type_sub_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              capture_c;
  logic              word_is_last_c;
  logic [LEN_W-1:0]  len_clamped_c;
  logic [DATA_W-1:0] data_shifted_c;
  logic [15:0]       payload_word_c;

  // Request is taken only from IDLE and never while reset is held.
  assign capture_c      = (state_q == ST_IDLE) && event_available && !rst;
  assign len_clamped_c  = (data_num_words > LEN_W'(MAX_DATA_NUM_WORDS))
                          ? LEN_W'(MAX_DATA_NUM_WORDS) : data_num_words;
  assign word_is_last_c = ((word_q + LEN_W'(1)) == len_q);
  assign data_shifted_c = data_q >> {word_q, 4'b0000};
  assign payload_word_c = data_shifted_c[15:0];

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      len_q      <= '0;
      dest_q     <= '0;
      id_q       <= '0;
      type_sub_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      len_q      <= len_d;
      dest_q     <= dest_d;
      id_q       <= id_d;
      type_sub_q <= type_sub_d;
      data_q     <= data_d;
    end
  end

  // Next-state: capture in IDLE, advance one flit per accepted transfer.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    len_d      = len_q;
    dest_d     = dest_q;
    id_d       = id_q;
    type_sub_d = type_sub_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_c) begin
          state_d    = ST_DEST;
          word_d     = '0;
          len_d      = len_clamped_c;
          dest_d     = dest;
          id_d       = id;
          type_sub_d = type_sub;
          data_d     = data;
        end
      end
      ST_DEST: begin
        if (debug_out_ready) state_d = ST_SRC;
      end
      ST_SRC: begin
        if (debug_out_ready) state_d = ST_FLAGS;
      end
      ST_FLAGS: begin
        if (debug_out_ready) begin
          state_d = (len_q == '0) ? ST_IDLE : ST_PAYLOAD;
          word_d  = '0;
        end
      end
      ST_PAYLOAD: begin
        if (debug_out_ready) begin
          if (word_is_last_c) begin
            state_d = ST_IDLE;
            word_d  = '0;
          end else begin
            word_d  = word_q + LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        word_d  = '0;
      end
    endcase
  end

  // Flit decode from registered state only; valid doubles as the in-packet flag.
  always_comb begin
    debug_out      = '0;
    event_consumed = capture_c;
    case (state_q)
      ST_DEST: begin
        debug_out.valid = 1'b1;
        debug_out.data  = dest_q;
      end
      ST_SRC: begin
        debug_out.valid = 1'b1;
        debug_out.data  = id_q;
      end
      ST_FLAGS: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {PKT_TYPE, type_sub_q, 10'b0};
        debug_out.last  = (len_q == '0);
      end
      ST_PAYLOAD: begin
        debug_out.valid = 1'b1;
        debug_out.data  = payload_word_c;
        debug_out.last  = word_is_last_c;
      end
      default: begin
        debug_out = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_peripheral_dbg_soc_dii_packetizer.sv
// Directed, table-driven bench for the DII event packetizer.
module tb_peripheral_dbg_soc_dii_packetizer;
  import peripheral_dbg_soc_dii_packetizer_pkg::*;

  localparam int unsigned MAXW = 8;

  logic             clk;
  logic             rst;
  logic [15:0]      id;
  logic [15:0]      dest;
  logic [3:0]       type_sub;
  logic             event_available;
  logic             event_consumed;
  logic [3:0]       data_num_words;
  logic [MAXW*16-1:0] data;
  dii_flit          debug_out;
  logic             debug_out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]  dest;
    logic [15:0]  id;
    logic [3:0]   ts;
    logic [3:0]   nw;
    logic [127:0] data;
    logic [15:0]  exp_flags;
    int           exp_len;
  } pkt_t;

  pkt_t vec [6];

  peripheral_dbg_soc_dii_packetizer #(
    .MAX_DATA_NUM_WORDS(MAXW),
    .PKT_TYPE(2'b10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id(id),
    .dest(dest),
    .type_sub(type_sub),
    .event_available(event_available),
    .event_consumed(event_consumed),
    .data_num_words(data_num_words),
    .data(data),
    .debug_out(debug_out),
    .debug_out_ready(debug_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_flit(input pkt_t p, input int i);
    logic [127:0] sh;
    if (i == 0) return p.dest;
    if (i == 1) return p.id;
    if (i == 2) return p.exp_flags;
    sh = p.data >> (16 * (i - 3));
    return sh[15:0];
  endfunction

  // Starts at posedge+1 (or +2) with DUT in IDLE; returns at posedge+2 in the gap cycle.
  task automatic run_pkt(input pkt_t p, input int stall_max, input bit keep_avail, input int n_flits);
    int stalls;
    dest            = p.dest;
    id              = p.id;
    type_sub        = p.ts;
    data_num_words  = p.nw;
    data            = p.data;
    event_available = 1'b1;
    debug_out_ready = 1'b1;
    #1;
    chk("capture_consumed", 32'(event_consumed), 32'd1);
    chk("capture_idle_valid", 32'(debug_out.valid), 32'd0);
    @(posedge clk); #1;
    if (!keep_avail) begin
      event_available = 1'b0;
      dest            = 16'($urandom);
      id              = 16'($urandom);
      type_sub        = 4'($urandom);
      data_num_words  = 4'($urandom);
      data            = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int i = 0; i < n_flits; i++) begin
      stalls = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      for (int s = 0; s <= stalls; s++) begin
        debug_out_ready = (s == stalls);
        #1;
        chk($sformatf("flit%0d_valid", i), 32'(debug_out.valid), 32'd1);
        chk($sformatf("flit%0d_data", i), 32'(debug_out.data), 32'(exp_flit(p, i)));
        chk($sformatf("flit%0d_last", i), 32'(debug_out.last), 32'(i == n_flits - 1));
        chk($sformatf("flit%0d_no_consume", i), 32'(event_consumed), 32'd0);
        @(posedge clk); #1;
      end
    end
    debug_out_ready = 1'b1;
    #1;
    chk("gap_valid", 32'(debug_out.valid), 32'd0);
    chk("gap_consumed", 32'(event_consumed), 32'(keep_avail));
  endtask

  initial begin
    vec[0] = '{16'h0001, 16'h0005, 4'h3, 4'd2,
               128'h7777_6666_5555_4444_3333_2222_BBBB_AAAA, 16'h8C00, 2};
    vec[1] = '{16'h1234, 16'h5678, 4'hF, 4'd0,
               128'h1111_1111_1111_1111_1111_1111_1111_1111, 16'hBC00, 0};
    vec[2] = '{16'h00FF, 16'h0F00, 4'h0, 4'd15,
               128'h1007_1006_1005_1004_1003_1002_1001_1000, 16'h8000, 8};
    vec[3] = '{16'hABCD, 16'h4321, 4'hA, 4'd8,
               128'hF0F0_0F0F_FFFF_0000_8001_7FFE_DEAD_BEEF, 16'hA800, 8};
    vec[4] = '{16'h0000, 16'hFFFF, 4'h5, 4'd1,
               128'h9999_9999_9999_9999_9999_9999_9999_1234, 16'h9400, 1};
    vec[5] = '{16'h0A0A, 16'h0B0B, 4'h1, 4'd4,
               128'h5555_5555_5555_5555_4444_3333_2222_1111, 16'h8400, 4};

    rst             = 1'b1;
    id              = '0;
    dest            = '0;
    type_sub        = '0;
    data_num_words  = '0;
    data            = '0;
    event_available = 1'b1;
    debug_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(debug_out.valid), 32'd0);
    chk("rst_last", 32'(debug_out.last), 32'd0);
    chk("rst_data", 32'(debug_out.data), 32'd0);
    chk("rst_consumed", 32'(event_consumed), 32'd0);
    rst             = 1'b0;
    event_available = 1'b0;
    @(posedge clk); #1;

    // Table: each packet with ready held high.
    for (int k = 0; k < 6; k++) begin
      run_pkt(vec[k], 0, 1'b0, 3 + vec[k].exp_len);
    end

    // Random ready stalls on a 4-word packet.
    run_pkt(vec[5], 5, 1'b0, 7);
    run_pkt(vec[5], 5, 1'b0, 7);

    // event_available held for three back-to-back packets.
    run_pkt(vec[0], 0, 1'b1, 5);
    run_pkt(vec[0], 0, 1'b1, 5);
    run_pkt(vec[0], 0, 1'b1, 5);
    event_available = 1'b0;

    // Reset while payload word 1 is pending.
    dest            = vec[5].dest;
    id              = vec[5].id;
    type_sub        = vec[5].ts;
    data_num_words  = vec[5].nw;
    data            = vec[5].data;
    event_available = 1'b1;
    #1;
    chk("rstmid_capture", 32'(event_consumed), 32'd1);
    @(posedge clk); #1;
    event_available = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rstmid_flit%0d", i), 32'(debug_out.data), 32'(exp_flit(vec[5], i)));
      @(posedge clk); #1;
    end
    debug_out_ready = 1'b0;
    #1;
    chk("rstmid_pending_valid", 32'(debug_out.valid), 32'd1);
    chk("rstmid_pending_data", 32'(debug_out.data), 32'h2222);
    rst             = 1'b1;
    event_available = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_valid", 32'(debug_out.valid), 32'd0);
    chk("rstmid_data", 32'(debug_out.data), 32'd0);
    chk("rstmid_last", 32'(debug_out.last), 32'd0);
    chk("rstmid_consumed", 32'(event_consumed), 32'd0);
    @(posedge clk); #1;
    rst             = 1'b0;
    event_available = 1'b0;
    debug_out_ready = 1'b1;
    #1;
    chk("post_rst_idle", 32'(debug_out.valid), 32'd0);
    run_pkt(vec[0], 0, 1'b0, 5);
    run_pkt(vec[1], 2, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
